lc3_fetch_queue: RTL and testbench
==================================

LC3_FETCH_QUEUE -- requirements
Module: lc3_fetch_queue

Interface
REQ-001 Parameter RESET_PC, default 16'h3000: PC value loaded on reset.
REQ-002 Parameter DEPTH, default 2: instruction queue entries; legal values 2..4.
REQ-003 clock  in  1  sole clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 br_taken  in  1  redirect request from control/execute; flushes the queue.
REQ-006 taddr  in  16  redirect target PC, sampled when br_taken=1.
REQ-007 imem_req  out  1  registered one-cycle instruction-memory read strobe.
REQ-008 imem_addr  out  16  registered read address, valid while imem_req=1.
REQ-009 imem_rvalid  in  1  read-data-valid strobe from instruction memory.
REQ-010 imem_rdata  in  16  instruction word, valid when imem_rvalid=1.
REQ-011 instr_valid  out  1  queue head valid toward decode.
REQ-012 dec_ready  in  1  decode accepts the head this cycle.
REQ-013 instr_out  out  16  head instruction word.
REQ-014 pc_out  out  16  head instruction address.
REQ-015 npc_out  out  16  head address + 1, modulo 2^16.

Function
REQ-016 State machine SHALL have states IDLE, WAIT and DROP, with at most one memory read outstanding.
REQ-017 IDLE, br_taken=0, count<DEPTH: next edge sets imem_req=1, imem_addr=pc, req_pc=pc, pc=pc+1 (mod 2^16), state=WAIT.
REQ-018 IDLE with count==DEPTH: no request issued, state remains IDLE.
REQ-019 imem_req SHALL be high for exactly one cycle per request.
REQ-020 WAIT, imem_rvalid=1, br_taken=0: push {imem_rdata, req_pc, req_pc+1} at the queue tail, state=IDLE.
REQ-021 imem_rvalid is legal no earlier than the cycle after imem_req; imem_rvalid in IDLE SHALL be ignored.
REQ-022 Handshake: a head entry pops when instr_valid=1 and dec_ready=1; instr_valid=(count!=0), combinational from registered count.
REQ-023 Push and pop in the same cycle: count is unchanged and entry order is preserved.
REQ-024 The queue SHALL never overflow; a push at count==DEPTH is impossible by REQ-017 and needs no further guard.
REQ-025 br_taken=1, any state: next edge sets pc=taddr and count=0; the pop and push of that cycle are discarded.
REQ-026 br_taken in WAIT with imem_rvalid=0: state=DROP.
REQ-027 br_taken in WAIT with imem_rvalid=1 in the same cycle: response discarded, state=IDLE.
REQ-028 DROP: next imem_rvalid is discarded, state=IDLE; br_taken in DROP updates pc and keeps DROP.
REQ-029 br_taken in IDLE: no request in that cycle; the first request to taddr goes out no earlier than the following IDLE cycle.
REQ-030 Queue storage SHALL be a circular buffer with head/tail pointers wrapping modulo DEPTH.

Reset
REQ-031 On reset assertion, asynchronously: pc=RESET_PC, state=IDLE, count=0, pointers=0, imem_req=0, imem_addr=0, req_pc=0.
REQ-032 Reset values on outputs: instr_valid=0; instr_out, pc_out and npc_out read as 0 while the queue is empty after reset.
REQ-033 Reset mid-WAIT or mid-DROP: any later stale imem_rvalid arrives in IDLE and is ignored per REQ-021.

Verification
REQ-034 Release reset, memory latency 1, rdata=16'h1234, dec_ready=1 -> imem_req with imem_addr=16'h3000 on the first edge after release; instr_valid with instr_out=16'h1234, pc_out=16'h3000, npc_out=16'h3001.
REQ-035 dec_ready=0, latency 1 -> addresses 16'h3000 and 16'h3001 fetched, then no further imem_req while count=2; dec_ready=1 pops 16'h3000 first, then a request to 16'h3002 issues.
REQ-036 br_taken with taddr=16'h4000 in WAIT, response 3 cycles later -> response dropped, queue empty, next imem_addr=16'h4000.
REQ-037 br_taken and imem_rvalid in the same WAIT cycle, with dec_ready=1 and count=1 -> instr_valid=0 next cycle, next imem_addr=taddr.
REQ-038 br_taken with taddr=16'hFFFF -> entry shows pc_out=16'hFFFF, npc_out=16'h0000; the following imem_addr=16'h0000.
REQ-039 Reset asserted mid-WAIT, stale imem_rvalid after release -> ignored; first request to 16'h3000, and instr_valid stays 0 until that response returns.

Source files
------------

// File: rtl/lc3_fetch_queue.sv
// LC-3 instruction fetch unit: issues single-outstanding memory reads and
// buffers returned words in a small circular queue toward decode.
module lc3_fetch_queue #(
  parameter logic [15:0] RESET_PC = 16'h3000,
  parameter int          DEPTH    = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        br_taken,
  input  logic [15:0] taddr,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [15:0] imem_rdata,
  output logic        instr_valid,
  input  logic        dec_ready,
  output logic [15:0] instr_out,
  output logic [15:0] pc_out,
  output logic [15:0] npc_out
);

  localparam int PW = (DEPTH > 2) ? 2 : 1;
  localparam int CW = 3;

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t          state_q, state_d;
  logic [15:0]     pc_q, pc_d;
  logic [15:0]     req_pc_q, req_pc_d;
  logic            imem_req_q, imem_req_d;
  logic [15:0]     imem_addr_q, imem_addr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [15:0]     instr_q [DEPTH];
  logic [15:0]     instr_d [DEPTH];
  logic [15:0]     epc_q [DEPTH];
  logic [15:0]     epc_d [DEPTH];
  logic [15:0]     enpc_q [DEPTH];
  logic [15:0]     enpc_d [DEPTH];
  logic            push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    imem_req_d  = 1'b0;
    imem_addr_d = imem_addr_q;
    head_d      = head_q;
    tail_d      = tail_q;
    instr_d     = instr_q;
    epc_d       = epc_q;
    enpc_d      = enpc_q;
    push        = 1'b0;
    pop         = 1'b0;

    if (br_taken) begin
      pc_d   = taddr;
      head_d = '0;
      tail_d = '0;
      // A response arriving with the redirect still retires the outstanding read.
      case (state_q)
        WAIT:    state_d = imem_rvalid ? IDLE : DROP;
        DROP:    state_d = imem_rvalid ? IDLE : DROP;
        default: state_d = IDLE;
      endcase
    end else begin
      pop = instr_valid & dec_ready;
      case (state_q)
        IDLE: begin
          if (count_q < CW'(DEPTH)) begin
            imem_req_d  = 1'b1;
            imem_addr_d = pc_q;
            req_pc_d    = pc_q;
            pc_d        = pc_q + 16'd1;
            state_d     = WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            push            = 1'b1;
            instr_d[tail_q] = imem_rdata;
            epc_d[tail_q]   = req_pc_q;
            enpc_d[tail_q]  = req_pc_q + 16'd1;
            tail_d          = ptr_inc(tail_q);
            state_d         = IDLE;
          end
        end
        DROP: begin
          if (imem_rvalid) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
      if (pop) head_d = ptr_inc(head_q);
    end

    count_d = br_taken ? '0 : count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      req_pc_q    <= '0;
      imem_req_q  <= 1'b0;
      imem_addr_q <= '0;
      count_q     <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        epc_q[i]   <= '0;
        enpc_q[i]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      imem_req_q  <= imem_req_d;
      imem_addr_q <= imem_addr_d;
      count_q     <= count_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      instr_q     <= instr_d;
      epc_q       <= epc_d;
      enpc_q      <= enpc_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = imem_addr_q;
  assign instr_valid = (count_q != '0);
  assign instr_out   = instr_q[head_q];
  assign pc_out      = epc_q[head_q];
  assign npc_out     = enpc_q[head_q];

endmodule

// File: tb/tb_lc3_fetch_queue.sv
// Directed self-checking bench for lc3_fetch_queue; the memory side is driven
// by hand, one step at a time.
module tb_lc3_fetch_queue;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        br_taken = 1'b0;
  logic [15:0] taddr = '0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic        instr_valid;
  logic        dec_ready = 1'b0;
  logic [15:0] instr_out;
  logic [15:0] pc_out;
  logic [15:0] npc_out;

  int tests = 0;
  int fails = 0;

  lc3_fetch_queue #(.RESET_PC(16'h3000), .DEPTH(2)) dut (
    .clock(clock), .reset(reset), .br_taken(br_taken), .taddr(taddr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .instr_valid(instr_valid), .dec_ready(dec_ready),
    .instr_out(instr_out), .pc_out(pc_out), .npc_out(npc_out)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_head(input string tag, input logic [15:0] ins,
                            input logic [15:0] pc, input logic [15:0] npc);
    check({tag, "_valid"}, {15'd0, instr_valid}, 16'd1);
    check({tag, "_instr"}, instr_out, ins);
    check({tag, "_pc"}, pc_out, pc);
    check({tag, "_npc"}, npc_out, npc);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    br_taken = 1'b0;
    imem_rvalid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    // Reset values
    tick();
    tick();
    check("rst_req", {15'd0, imem_req}, 16'd0);
    check("rst_addr", imem_addr, 16'h0000);
    check("rst_valid", {15'd0, instr_valid}, 16'd0);
    check("rst_instr", instr_out, 16'h0000);
    check("rst_pc", pc_out, 16'h0000);
    check("rst_npc", npc_out, 16'h0000);
    reset = 1'b0;
    dec_ready = 1'b1;

    // Basic fetch, latency 1
    tick();
    check("a_req", {15'd0, imem_req}, 16'd1);
    check("a_addr", imem_addr, 16'h3000);
    tick();
    check("a_req_oneshot", {15'd0, imem_req}, 16'd0);
    imem_rvalid = 1'b1; imem_rdata = 16'h1234;
    tick();
    imem_rvalid = 1'b0;
    check_head("a_head", 16'h1234, 16'h3000, 16'h3001);
    tick();
    check("a_popped", {15'd0, instr_valid}, 16'd0);
    check("a_req2_addr", imem_addr, 16'h3001);

    // Full queue back-pressure
    dec_ready = 1'b0;
    do_reset();
    tick();
    check("b_addr0", imem_addr, 16'h3000);
    tick();
    imem_rvalid = 1'b1; imem_rdata = 16'h1111;
    tick();
    imem_rvalid = 1'b0;
    check_head("b_head0", 16'h1111, 16'h3000, 16'h3001);
    tick();
    check("b_req1", {15'd0, imem_req}, 16'd1);
    check("b_addr1", imem_addr, 16'h3001);
    tick();
    imem_rvalid = 1'b1; imem_rdata = 16'h2222;
    tick();
    imem_rvalid = 1'b0;
    check_head("b_full_head", 16'h1111, 16'h3000, 16'h3001);
    tick();
    check("b_full_noreq1", {15'd0, imem_req}, 16'd0);
    tick();
    check("b_full_noreq2", {15'd0, imem_req}, 16'd0);
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
    check("b_pop_noreq", {15'd0, imem_req}, 16'd0);
    check_head("b_head1", 16'h2222, 16'h3001, 16'h3002);
    tick();
    check("b_req2", {15'd0, imem_req}, 16'd1);
    check("b_addr2", imem_addr, 16'h3002);

    // Redirect in WAIT, late response dropped
    br_taken = 1'b1; taddr = 16'h4000;
    tick();
    br_taken = 1'b0;
    check("c_flush_valid", {15'd0, instr_valid}, 16'd0);
    check("c_noreq0", {15'd0, imem_req}, 16'd0);
    tick();
    tick();
    imem_rvalid = 1'b1; imem_rdata = 16'hDEAD;
    tick();
    imem_rvalid = 1'b0;
    check("c_drop_valid", {15'd0, instr_valid}, 16'd0);
    check("c_noreq1", {15'd0, imem_req}, 16'd0);
    tick();
    check("c_req", {15'd0, imem_req}, 16'd1);
    check("c_addr", imem_addr, 16'h4000);

    // Redirect and response in the same WAIT cycle, count=1, dec_ready=1
    tick();
    imem_rvalid = 1'b1; imem_rdata = 16'h5555;
    tick();
    imem_rvalid = 1'b0;
    check_head("d_head", 16'h5555, 16'h4000, 16'h4001);
    tick();
    check("d_addr", imem_addr, 16'h4001);
    tick();
    br_taken = 1'b1; taddr = 16'h5000;
    imem_rvalid = 1'b1; imem_rdata = 16'h6666;
    dec_ready = 1'b1;
    tick();
    br_taken = 1'b0; imem_rvalid = 1'b0; dec_ready = 1'b0;
    check("d_flush_valid", {15'd0, instr_valid}, 16'd0);
    check("d_noreq", {15'd0, imem_req}, 16'd0);
    tick();
    check("d_req", {15'd0, imem_req}, 16'd1);
    check("d_taddr", imem_addr, 16'h5000);

    // Redirect to the top of memory, PC wrap
    br_taken = 1'b1; taddr = 16'hFFFF;
    tick();
    br_taken = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 16'hBEEF;
    tick();
    imem_rvalid = 1'b0;
    check("e_drop_valid", {15'd0, instr_valid}, 16'd0);
    tick();
    check("e_addr_ffff", imem_addr, 16'hFFFF);
    tick();
    imem_rvalid = 1'b1; imem_rdata = 16'h7777;
    tick();
    imem_rvalid = 1'b0;
    check_head("e_head", 16'h7777, 16'hFFFF, 16'h0000);
    tick();
    check("e_req_wrap", {15'd0, imem_req}, 16'd1);
    check("e_addr_wrap", imem_addr, 16'h0000);

    // Reset mid-WAIT, stale response afterwards
    #2;
    reset = 1'b1;
    #1;
    check("f_async_req", {15'd0, imem_req}, 16'd0);
    check("f_async_valid", {15'd0, instr_valid}, 16'd0);
    tick();
    reset = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 16'hBAD0;
    tick();
    imem_rvalid = 1'b0;
    check("f_stale_valid", {15'd0, instr_valid}, 16'd0);
    check("f_req", {15'd0, imem_req}, 16'd1);
    check("f_addr", imem_addr, 16'h3000);
    tick();
    check("f_wait_valid", {15'd0, instr_valid}, 16'd0);
    imem_rvalid = 1'b1; imem_rdata = 16'h8888;
    tick();
    imem_rvalid = 1'b0;
    check_head("f_head", 16'h8888, 16'h3000, 16'h3001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
